// File: rtl/wildcube_pkg.sv
// rtl/wildcube_pkg.sv - shared Wild Cube playfield constants and gap FSM state type
package wildcube_pkg;
   localparam int COORD_W_DEF = 16;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int PF_X_MIN    = 10;
   localparam int PF_X_MAX    = SCREEN_W - 1 - PF_X_MIN;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RIGHT = 2'd1,
      LEFT  = 2'd2
   } gap_state_t;
endpackage

// File: rtl/gap_bounce_ctr.sv
// rtl/gap_bounce_ctr.sv - per-frame gap mover: bounce FSM, gap position/length, limits
module gap_bounce_ctr
   import wildcube_pkg::*;
#(
   parameter int COORD_W   = COORD_W_DEF,
   parameter int X_MIN     = PF_X_MIN,
   parameter int X_MAX     = PF_X_MAX,
   parameter int GAP_INIT  = 60,
   parameter int SEL_W     = 3,
   parameter int LEN_SHIFT = 5,
   parameter int STEP      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               load,
   input  logic               run,
   input  logic [SEL_W-1:0]   gap_sel,
   output logic [COORD_W-1:0] gap_pos,
   output logic [COORD_W-1:0] gap_len,
   output logic               dir_left,
   output logic               bounce
);
   localparam logic [COORD_W:0]   LIM_TOP  = (COORD_W+1)'(X_MAX + 1);
   localparam logic [COORD_W:0]   LO_LIM   = (COORD_W+1)'(X_MIN);
   localparam logic [COORD_W:0]   STEP_E   = (COORD_W+1)'(STEP);
   localparam logic [COORD_W-1:0] POS_INIT = COORD_W'(GAP_INIT);

   gap_state_t         state, state_nx;
   logic [COORD_W-1:0] pos_nx, len_nx, len_tick;
   logic [COORD_W:0]   hi_lim, pos_e, pos_mv;
   logic               bounce_nx;

   assign len_tick = {{(COORD_W-SEL_W){1'b0}}, gap_sel} << LEN_SHIFT;
   assign pos_e    = {1'b0, gap_pos};
   assign dir_left = (state == LEFT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gap_pos <= POS_INIT;
         gap_len <= '0;
         bounce  <= 1'b0;
      end else begin
         state   <= state_nx;
         gap_pos <= pos_nx;
         gap_len <= len_nx;
         bounce  <= bounce_nx;
      end
   end

   // Limits follow the length sampled on this tick so a longer gap clamps immediately.
   always_comb begin
      state_nx  = state;
      pos_nx    = gap_pos;
      len_nx    = gap_len;
      bounce_nx = 1'b0;
      hi_lim    = LIM_TOP - {1'b0, gap_len};
      pos_mv    = pos_e;
      if (load) begin
         state_nx = IDLE;
         pos_nx   = POS_INIT;
      end else if (frame_tick) begin
         len_nx = len_tick;
         hi_lim = LIM_TOP - {1'b0, len_tick};
         if (run) begin
            case (state)
               IDLE: if (start) state_nx = RIGHT;
               RIGHT: begin
                  if (pos_e + STEP_E >= hi_lim) begin
                     pos_mv    = hi_lim;
                     state_nx  = LEFT;
                     bounce_nx = 1'b1;
                  end else begin
                     pos_mv = pos_e + STEP_E;
                  end
               end
               LEFT: begin
                  if (pos_e < LO_LIM + STEP_E) begin
                     pos_mv    = LO_LIM;
                     state_nx  = RIGHT;
                     bounce_nx = 1'b1;
                  end else begin
                     pos_mv = pos_e - STEP_E;
                  end
               end
               default: state_nx = IDLE;
            endcase
         end
         if (pos_mv > hi_lim) pos_mv = hi_lim;
         pos_nx = pos_mv[COORD_W-1:0];
      end
   end
endmodule

// File: rtl/h_line_gap_gen.sv
// rtl/h_line_gap_gen.sv - horizontal bar with moving gap; HLINE_HIT_DETECT_EN adds sticky hit flag
module h_line_gap_gen
   import wildcube_pkg::*;
#(
   parameter int COORD_W   = COORD_W_DEF,
   parameter int ROW_TOP   = 178,
   parameter int THICK     = 9,
   parameter int X_MIN     = PF_X_MIN,
   parameter int X_MAX     = PF_X_MAX,
   parameter int GAP_INIT  = 60,
   parameter int SEL_W     = 3,
   parameter int LEN_SHIFT = 5,
   parameter int STEP      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               load,
   input  logic               run,
   input  logic               flash,
   input  logic [SEL_W-1:0]   gap_sel,
   input  logic               obj,
   output logic               h_line,
   output logic               shape,
   output logic [COORD_W-1:0] gap_pos,
   output logic               dir_left,
   output logic               bounce,
   output logic               hit
);
   localparam logic [COORD_W-1:0] ROW_LO = COORD_W'(ROW_TOP);
   localparam logic [COORD_W-1:0] ROW_HI = COORD_W'(ROW_TOP + THICK - 1);
   localparam logic [COORD_W-1:0] XL     = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] XR     = COORD_W'(X_MAX);

   logic [COORD_W-1:0] gap_len;
   logic [COORD_W:0]   gap_end;
   logic               row_hit, left_seg, right_seg, shape_d;

   gap_bounce_ctr #(
      .COORD_W(COORD_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .GAP_INIT(GAP_INIT),
      .SEL_W(SEL_W), .LEN_SHIFT(LEN_SHIFT), .STEP(STEP)
   ) u_ctr (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .load(load), .run(run), .gap_sel(gap_sel), .gap_pos(gap_pos),
      .gap_len(gap_len), .dir_left(dir_left), .bounce(bounce)
   );

   assign gap_end   = {1'b0, gap_pos} + {1'b0, gap_len};
   assign row_hit   = (y >= ROW_LO) && (y <= ROW_HI);
   assign left_seg  = (x >= XL) && (x < gap_pos);
   assign right_seg = ({1'b0, x} >= gap_end) && (x <= XR);
   assign shape_d   = row_hit && (left_seg || right_seg);

   always_ff @(posedge clk) begin
      if (reset) begin
         shape  <= 1'b0;
         h_line <= 1'b0;
      end else begin
         shape  <= shape_d;
         h_line <= shape_d && (run || flash);
      end
   end

`ifdef HLINE_HIT_DETECT_EN
   logic hit_r;
   always_ff @(posedge clk) begin
      if (reset || load) hit_r <= 1'b0;
      else if (obj && shape_d && run) hit_r <= 1'b1;
   end
   assign hit = hit_r;
`else
   logic unused_obj;
   assign unused_obj = obj;
   assign hit = 1'b0;
`endif
endmodule
